// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEFAULT = 10;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// arb_select: combinational winner selection between the two requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise port 0 always wins.
module arb_select
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the grant to whichever port did not win last time.
    always_comb begin
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = ~req0;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between a CPU (port 0) and a loader (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build is fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_writeen,
    output logic [DW-1:0] mem_writeint,
    input  logic [DW-1:0] mem_RD
);

    arb_state_t    state_reg, state_next;
    logic          grant;
    logic          grant_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;
    logic          last_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    // Reset to 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (ack0 || ack1) begin
            last_grant_reg <= grant;
        end
    end

    assign last_grant = last_grant_reg;
`else
    assign last_grant = 1'b1;
`endif

    arb_select u_arb_select (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Handshake pulses are decoded from the current state; reset masks them so
    // an in-flight write or read response is dropped rather than retried.
    always_comb begin
        state_next  = state_reg;
        ack0        = 1'b0;
        ack1        = 1'b0;
        rvalid0     = 1'b0;
        rvalid1     = 1'b0;
        mem_writeen = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_next = ACCESS;
                        ack0       = ~grant;
                        ack1       = grant;
                    end
                end
                ACCESS: begin
                    state_next  = RESP;
                    mem_writeen = we_reg;
                end
                RESP: begin
                    state_next = IDLE;
                    rvalid0    = ~we_reg & ~grant_reg;
                    rvalid1    = ~we_reg & grant_reg;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ack0 || ack1) begin
                grant_reg <= grant;
                we_reg    <= grant ? we1    : we0;
                addr_reg  <= grant ? addr1  : addr0;
                wdata_reg <= grant ? wdata1 : wdata0;
            end
            if (state_reg == ACCESS && !we_reg) begin
                rdata_reg <= mem_RD;
            end
        end
    end

    assign mem_addr     = addr_reg;
    assign mem_writeint = wdata_reg;
    assign rdata        = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, hand-written corner sequences,
// and random traffic checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_writeen;
    logic [DW-1:0] mem_writeint;
    logic [DW-1:0] mem_RD;
    logic          mem_init;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_writeen  (mem_writeen),
        .mem_writeint (mem_writeint),
        .mem_RD       (mem_RD)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(49 + 3 * i);
    endfunction

    // Data memory: combinational read, posedge write.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (mem_writeen) begin
            mem[mem_addr] <= mem_writeint;
        end
    end
    assign mem_RD = mem[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model: one transaction in flight at a time ----------------
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            acc_v, acc_we, acc_port, resp_v, resp_we, resp_port;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata, exp_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    bit            m_last;
`endif

    task automatic model_step();
        bit take, win;
        take = !rst && !acc_v && !resp_v && (req0 || req1);
`ifdef ARB_ROUND_ROBIN_EN
        win = (req0 && req1) ? !m_last : req1;
`else
        win = !req0;
`endif
        chk("m_ack0", ack0, take && !win);
        chk("m_ack1", ack1, take && win);
        chk("m_wen", mem_writeen, !rst && acc_v && acc_we);
        if (!rst && acc_v) begin
            chk("m_addr", mem_addr, acc_addr);
            if (acc_we) chk("m_wdata", mem_writeint, acc_wdata);
        end
        chk("m_rvalid0", rvalid0, !rst && resp_v && !resp_we && !resp_port);
        chk("m_rvalid1", rvalid1, !rst && resp_v && !resp_we && resp_port);
        if (!rst) chk("m_rdata", rdata, exp_rdata);
        if (rst) begin
            acc_v     = 0;
            resp_v    = 0;
            exp_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last    = 1;
`endif
        end else begin
            if (acc_v && acc_we)  ref_mem[acc_addr] = acc_wdata;
            if (acc_v && !acc_we) exp_rdata = ref_mem[acc_addr];
            resp_v    = acc_v;
            resp_we   = acc_we;
            resp_port = acc_port;
            acc_v     = take;
            if (take) begin
                acc_port  = win;
                acc_we    = win ? we1 : we0;
                acc_addr  = win ? addr1 : addr0;
                acc_wdata = win ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
                m_last    = win;
`endif
            end
        end
    endtask

    initial begin : monitor
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        acc_v = 0; resp_v = 0; exp_rdata = '0;
        acc_we = 0; acc_port = 0; resp_we = 0; resp_port = 0;
        acc_addr = '0; acc_wdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
        m_last = 1;
`endif
        forever begin
            @(negedge clk);
            #2;
            model_step();
        end
    end

    // ---------------- directed transactions ----------------
    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            exp_rvalid;
        logic [DW-1:0] exp_rdata;
    } txn_t;

    txn_t tbl [6];

    task automatic scramble_fields();
        we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
        we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
    endtask

    // Issue one request into an idle arbiter and check the T / T+1 / T+2 timeline.
    task automatic run_txn(input txn_t t);
        @(negedge clk);
        if (t.port) begin
            req1 = 1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
        end else begin
            req0 = 1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
        end
        #1;
        $display("txn port=%0d we=%0d addr=%0d wdata=%0h", t.port, t.we, t.addr, t.wdata);
        chk("t_ack", t.port ? ack1 : ack0, 1);
        chk("t_ack_other", t.port ? ack0 : ack1, 0);
        chk("t_wen_T", mem_writeen, 0);
        @(negedge clk);
        req0 = 0; req1 = 0;
        scramble_fields();
        #1;
        chk("t_wen_T1", mem_writeen, t.we);
        chk("t_addr_T1", mem_addr, t.addr);
        if (t.we) chk("t_wdata_T1", mem_writeint, t.wdata);
        chk("t_rvalid_T1", {rvalid1, rvalid0}, 0);
        @(negedge clk);
        #1;
        chk("t_rvalid_T2", t.port ? rvalid1 : rvalid0, t.exp_rvalid);
        chk("t_rvalid_other_T2", t.port ? rvalid0 : rvalid1, 0);
        chk("t_wen_T2", mem_writeen, 0);
        if (t.exp_rvalid) chk("t_rdata_T2", rdata, t.exp_rdata);
    endtask

    initial begin : stimulus
        bit   p0, p1;
        bit   exp0, exp1, gport;
        txn_t t;

        rst = 1; mem_init = 1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        tbl[0] = '{0, 1, 10'd5,    32'h31,       0, 32'h0};
        tbl[1] = '{0, 0, 10'd5,    32'h0,        1, 32'h31};
        tbl[2] = '{1, 1, 10'd1023, 32'hFFFFFFFF, 0, 32'h0};
        tbl[3] = '{1, 0, 10'd1023, 32'h0,        1, 32'hFFFFFFFF};
        tbl[4] = '{0, 0, 10'd0,    32'h0,        1, 32'd49};
        tbl[5] = '{1, 0, 10'd2,    32'h0,        1, 32'd55};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ack", {ack1, ack0}, 0);
        chk("reset_rvalid", {rvalid1, rvalid0}, 0);
        chk("reset_wen", mem_writeen, 0);
        rst = 0; mem_init = 0;
        #1;
        chk("reset_rdata", rdata, 0);
        chk("reset_mem_addr", mem_addr, 0);

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Reset in the ACCESS cycle of a write: no write, no retry, back to IDLE.
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 10'd2; wdata0 = 32'hAA;
        #1;
        chk("rstacc_ack", ack0, 1);
        @(negedge clk);
        req0 = 0; rst = 1;
        #1;
        chk("rstacc_wen", mem_writeen, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rstacc_mem2", mem[2], 32'd55);
        for (int c = 0; c < 3; c++) begin
            chk("rstacc_noretry_ack", ack0, 0);
            chk("rstacc_noretry_wen", mem_writeen, 0);
            chk("rstacc_noretry_rvalid", rvalid0, 0);
            @(negedge clk);
            #1;
        end
        t = '{0, 0, 10'd2, 32'h0, 1, 32'd55};
        run_txn(t);

        // Reset in the RESP cycle of a read: rvalid suppressed, rdata cleared.
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 10'd5;
        #1;
        chk("rstresp_ack", ack1, 1);
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rstresp_rvalid", rvalid1, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rstresp_rdata", rdata, 0);
        chk("rstresp_rvalid_after", rvalid1, 0);

        // Port 1 rises mid-transaction of a port 0 read.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 10'd0;
        #1;
        chk("mid_ack0", ack0, 1);
        @(negedge clk);
        req0 = 0; req1 = 1; we1 = 0; addr1 = 10'd1;
        #1;
        chk("mid_ack1_T1", ack1, 0);
        @(negedge clk);
        #1;
        chk("mid_rvalid0_T2", rvalid0, 1);
        chk("mid_rdata_T2", rdata, 32'd49);
        chk("mid_rvalid1_T2", rvalid1, 0);
        chk("mid_ack1_T2", ack1, 0);
        @(negedge clk);
        #1;
        chk("mid_ack1_T3", ack1, 1);
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        #1;
        chk("mid_rvalid1", rvalid1, 1);
        chk("mid_rvalid0_off", rvalid0, 0);
        chk("mid_rdata1", rdata, 32'd52);

        // Both ports reading continuously after a reset.
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        req0 = 1; we0 = 0; addr0 = 10'd3;
        req1 = 1; we1 = 0; addr1 = 10'd4;
        for (int c = 0; c < 12; c++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            gport = 1'((c / 3) % 2);
`else
            gport = 0;
`endif
            exp0 = (c % 3 == 0) && !gport;
            exp1 = (c % 3 == 0) && gport;
            chk("cont_ack0", ack0, exp0);
            chk("cont_ack1", ack1, exp1);
            @(negedge clk);
            if (c == 11) begin
                req0 = 0; req1 = 0;
            end
        end

        // Random traffic; requesters hold until acked, occasional resets.
        p0 = 0; p1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!p0) begin
                we0 = 1'($urandom); addr0 = AW'($urandom_range(0, 15)); wdata0 = $urandom;
                p0 = 1'($urandom_range(0, 1));
            end
            if (!p1) begin
                we1 = 1'($urandom); addr1 = AW'($urandom_range(0, 15)); wdata1 = $urandom;
                p1 = 1'($urandom_range(0, 1));
            end
            req0 = p0; req1 = p1;
            rst = ($urandom_range(0, 63) == 0);
            #1;
            if (ack0) p0 = 0;
            if (ack1) p1 = 0;
            @(negedge clk);
        end
        req0 = 0; req1 = 0; rst = 0;
        repeat (4) @(negedge clk);
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

endmodule
